// File: rtl/filter_sinc_pkg.sv
// Purpose: shared constants and helpers for the sinc decimation filters.
// Latency: n/a (package only).
// Backpressure: n/a; consumers are strobe-driven and never stall.
package filter_sinc_pkg;

   // Smallest legal decimation exponent; anything outside the legal range
   // decodes to the default rate.
   localparam int LOG2_MIN_DR     = 5;
   localparam int DEFAULT_LOG2_DR = 8;

   // Words discarded after reset or a rate change while the comb history
   // still holds samples from before the restart.
   localparam int SETTLE_WORDS    = 3;

   // A third-order integrator grows by 3 bits per doubling of the rate,
   // plus one bit so the largest in-range result is representable.
   function automatic int acc_width(input int log2_max_dr);
      return 1 + 3 * log2_max_dr;
   endfunction

endpackage

// File: rtl/sinc3_channel.sv
// Purpose: one sinc3 channel -- integrators, decimated comb, scale/saturate.
// Latency: comb registers one edge after comb_en; word is combinational from them.
// Backpressure: none; integrators advance on every en, comb on every comb_en.
//
// Ports:
//   mclkin, rst   clock and async active-low reset
//   clr           synchronous clear of all state (rate change)
//   en, x         sample strobe and modulator bit (0 -> 0, 1 -> +1)
//   comb_en       one-cycle pulse after the period-ending sample
//   log2_dr       effective decimation exponent used for scaling
//   word          scaled, saturated output of the latest comb result
module sinc3_channel
   import filter_sinc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ACC_W = 37
)
(
   input  logic             mclkin,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             x,
   input  logic             comb_en,
   input  logic [3:0]       log2_dr,
   output logic [WIDTH-1:0] word
);

   logic [ACC_W-1:0] acc1, acc2, acc3;
   logic [ACC_W-1:0] acc1_n, acc2_n, acc3_n;
   logic [ACC_W-1:0] acc3_prev, d1_prev, d2_prev, diff3;
   logic [ACC_W-1:0] d1, d2, d3;
   logic [ACC_W-1:0] scaled;
   logic             sat;
   int               lg3;

   // Integrators are chained within one cycle so acc3 already contains the
   // sample taken on the same edge; the comb then reads a settled register.
   assign acc1_n = acc1 + ACC_W'(x);
   assign acc2_n = acc2 + acc1_n;
   assign acc3_n = acc3 + acc2_n;

   assign d1 = acc3 - acc3_prev;
   assign d2 = d1 - d1_prev;
   assign d3 = d2 - d2_prev;

   always_ff @(posedge mclkin or negedge rst) begin
      if (!rst) begin
         acc1      <= '0;
         acc2      <= '0;
         acc3      <= '0;
         acc3_prev <= '0;
         d1_prev   <= '0;
         d2_prev   <= '0;
         diff3     <= '0;
      end else if (clr) begin
         acc1      <= '0;
         acc2      <= '0;
         acc3      <= '0;
         acc3_prev <= '0;
         d1_prev   <= '0;
         d2_prev   <= '0;
         diff3     <= '0;
      end else begin
         if (en) begin
            acc1 <= acc1_n;
            acc2 <= acc2_n;
            acc3 <= acc3_n;
         end
         if (comb_en) begin
            acc3_prev <= acc3;
            d1_prev   <= d1;
            d2_prev   <= d2;
            diff3     <= d3;
         end
      end
   end

   // Full scale of a sinc3 at rate 2^k is 2^(3k); align that to WIDTH bits.
   // Only an all-ones input reaches full scale, which cannot fit, so clamp.
   always_comb begin
      lg3    = 3 * int'(log2_dr);
      sat    = (lg3 < ACC_W) && ((diff3 >> lg3) != '0);
      scaled = (lg3 >= WIDTH) ? (diff3 >> (lg3 - WIDTH)) : (diff3 << (WIDTH - lg3));
      word   = sat ? '1 : scaled[WIDTH-1:0];
   end

endmodule

// File: rtl/filter_sinc3_mc.sv
// Purpose: multi-channel sinc3 decimator with shared rate control and settling.
// Latency: data/data_valid update 2 edges after the period-ending sample edge.
// Backpressure: none; mdata_en low freezes all state, output is a valid pulse.
//
// Ports:
//   mclkin, rst   clock and async active-low reset
//   mdata         one modulator bit per channel, sampled when mdata_en=1
//   dec_log2      decimation exponent; illegal values decode to the default
//   data          channel n at [n*WIDTH +: WIDTH], held between updates
//   data_valid    one-cycle pulse per accepted word
//   settled       high once the first unsuppressed word for this rate exists
module filter_sinc3_mc
   import filter_sinc_pkg::*;
#(
   parameter int CH          = 2,
   parameter int WIDTH       = 16,
   parameter int LOG2_MAX_DR = 12,
   parameter int ACC_W       = acc_width(LOG2_MAX_DR)
)
(
   input  logic                mclkin,
   input  logic                rst,
   input  logic [CH-1:0]       mdata,
   input  logic                mdata_en,
   input  logic [3:0]          dec_log2,
   output logic [CH*WIDTH-1:0] data,
   output logic                data_valid,
   output logic                settled
);

   logic [3:0]             eff, eff_q;
   logic                   primed, chg_q;
   logic [LOG2_MAX_DR-1:0] cnt, dr_m1;
   logic                   period_end, dec_end_q, comb_vld_q;
   logic [1:0]             settle_cnt;
   logic [CH*WIDTH-1:0]    words;

   always_comb begin
      eff = 4'(DEFAULT_LOG2_DR);
      if ((int'(dec_log2) >= LOG2_MIN_DR) && (int'(dec_log2) <= LOG2_MAX_DR))
         eff = dec_log2;
   end

   assign dr_m1      = LOG2_MAX_DR'((32'd1 << eff_q) - 32'd1);
   assign period_end = mdata_en && (cnt == dr_m1);

   // primed keeps the first post-reset load of eff_q from being seen as a
   // rate change, so the first sample after reset is always sample 0.
   always_ff @(posedge mclkin or negedge rst) begin
      if (!rst) begin
         eff_q      <= 4'(DEFAULT_LOG2_DR);
         primed     <= 1'b0;
         chg_q      <= 1'b0;
         cnt        <= '0;
         dec_end_q  <= 1'b0;
         comb_vld_q <= 1'b0;
         settle_cnt <= '0;
         settled    <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
      end else begin
         primed <= 1'b1;
         eff_q  <= eff;
         chg_q  <= primed && (eff_q != eff);
         if (chg_q) begin
            // Restart from scratch; any word in flight belongs to the old rate.
            cnt        <= '0;
            dec_end_q  <= 1'b0;
            comb_vld_q <= 1'b0;
            settle_cnt <= '0;
            settled    <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
         end else begin
            if (mdata_en)
               cnt <= period_end ? '0 : cnt + LOG2_MAX_DR'(1);
            dec_end_q  <= period_end;
            comb_vld_q <= dec_end_q;
            data_valid <= 1'b0;
            if (comb_vld_q) begin
               if (int'(settle_cnt) < SETTLE_WORDS) begin
                  settle_cnt <= settle_cnt + 2'd1;
               end else begin
                  data       <= words;
                  data_valid <= 1'b1;
                  settled    <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar n = 0; n < CH; n++) begin : g_ch
      sinc3_channel #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_ch (
         .mclkin  (mclkin),
         .rst     (rst),
         .clr     (chg_q),
         .en      (mdata_en),
         .x       (mdata[n]),
         .comb_en (dec_end_q),
         .log2_dr (eff_q),
         .word    (words[n*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_filter_sinc3_mc.sv
// Purpose: directed self-checking bench for filter_sinc3_mc (CH=2, WIDTH=16).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_filter_sinc3_mc;

   logic        mclkin;
   logic        rst;
   logic [1:0]  mdata;
   logic        mdata_en;
   logic [3:0]  dec_log2;
   logic [31:0] data;
   logic        data_valid;
   logic        settled;

   int vecs = 0;
   int errs = 0;
   int pat [2];      // 0 = zeros, 1 = ones, 2 = alternating
   int en_div = 1;   // mdata_en asserted every en_div cycles
   bit alt_ph = 1'b1;

   filter_sinc3_mc #(
      .CH          (2),
      .WIDTH       (16),
      .LOG2_MAX_DR (12),
      .ACC_W       (37)
   ) dut (
      .mclkin     (mclkin),
      .rst        (rst),
      .mdata      (mdata),
      .mdata_en   (mdata_en),
      .dec_log2   (dec_log2),
      .data       (data),
      .data_valid (data_valid),
      .settled    (settled)
   );

   initial begin
      mclkin = 1'b0;
      forever #5 mclkin = ~mclkin;
   end

   // Bitstream source: alternating channels toggle once per accepted sample.
   initial begin
      int cyc;
      cyc      = 0;
      mdata    = '0;
      mdata_en = 1'b0;
      forever begin
         @(posedge mclkin);
         #1;
         cyc++;
         mdata_en = ((cyc % en_div) == 0);
         if (mdata_en) begin
            for (int c = 0; c < 2; c++)
               mdata[c] = (pat[c] == 1) ? 1'b1 : (pat[c] == 2) ? alt_ph : 1'b0;
            alt_ph = ~alt_ph;
         end
      end
   end

   // Returns the number of rising edges until data_valid is seen (sampled on
   // the falling edge), or -1 if the budget expires.
   task automatic wait_valid(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge mclkin);
         @(negedge mclkin);
         if (data_valid === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic skip_valids(input int k, input int budget);
      int n;
      for (int j = 0; j < k; j++) begin
         wait_valid(budget, n);
         vecs++;
         if (n < 0) begin
            errs++;
            $display("FAIL skip_valid: data_valid absent for %0d cycles, required within %0d", budget, budget);
         end
      end
   endtask

   task automatic test_reset;
      rst      = 1'b0;
      dec_log2 = 4'd8;
      pat[0]   = 1;
      pat[1]   = 0;
      repeat (3) @(posedge mclkin);
      #1;
      vecs++;
      if (data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h required %h", data, 32'h0); end
      vecs++;
      if (data_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b required 0", data_valid); end
      vecs++;
      if (settled !== 1'b0) begin errs++; $display("FAIL reset_settled: got %b required 0", settled); end
   endtask

   task automatic test_settle_ones;
      int n;
      @(posedge mclkin);
      #1 rst = 1'b1;
      wait_valid(1100, n);
      vecs++;
      if (n !== 1026) begin errs++; $display("FAIL first_word_latency: got %0d required %0d", n, 1026); end
      vecs++;
      if (data !== 32'h0000_FFFF) begin errs++; $display("FAIL ones_zeros_word: got %h required %h", data, 32'h0000_FFFF); end
      vecs++;
      if (settled !== 1'b1) begin errs++; $display("FAIL settled_rise: got %b required 1", settled); end
   endtask

   task automatic test_back_to_back;
      int n;
      wait_valid(300, n);
      vecs++;
      if (n !== 256) begin errs++; $display("FAIL spacing_dr256: got %0d required %0d", n, 256); end
      vecs++;
      if (data !== 32'h0000_FFFF) begin errs++; $display("FAIL second_word: got %h required %h", data, 32'h0000_FFFF); end
      @(negedge mclkin);
      vecs++;
      if (data_valid !== 1'b0) begin errs++; $display("FAIL valid_pulse_width: got %b required 0", data_valid); end
   endtask

   task automatic test_alt8;
      int n;
      pat[0] = 2;
      pat[1] = 2;
      skip_valids(3, 300);
      wait_valid(300, n);
      vecs++;
      if (n !== 256) begin errs++; $display("FAIL alt8_spacing: got %0d required %0d", n, 256); end
      vecs++;
      if (data !== 32'h8000_8000) begin errs++; $display("FAIL alt8_word: got %h required %h", data, 32'h8000_8000); end
      repeat (100) @(negedge mclkin);
      vecs++;
      if ({data_valid, data} !== {1'b0, 32'h8000_8000})
         begin errs++; $display("FAIL hold_between_words: got %b/%h required 0/%h", data_valid, data, 32'h8000_8000); end
   endtask

   task automatic test_dr5;
      int n;
      @(posedge mclkin);
      #1 dec_log2 = 4'd5;
      wait_valid(200, n);
      vecs++;
      if (n !== 132) begin errs++; $display("FAIL dr5_first_latency: got %0d required %0d", n, 132); end
      vecs++;
      if (data !== 32'h8000_8000) begin errs++; $display("FAIL dr5_alt_word: got %h required %h", data, 32'h8000_8000); end
      pat[0] = 1;
      pat[1] = 1;
      skip_valids(3, 40);
      wait_valid(40, n);
      vecs++;
      if (n !== 32) begin errs++; $display("FAIL dr5_spacing: got %0d required %0d", n, 32); end
      vecs++;
      if (data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dr5_saturate: got %h required %h", data, 32'hFFFF_FFFF); end
   endtask

   task automatic test_en_every4;
      int n;
      pat[0] = 2;
      pat[1] = 2;
      @(posedge mclkin);
      #1;
      dec_log2 = 4'd6;
      en_div   = 4;
      skip_valids(1, 1200);
      wait_valid(300, n);
      vecs++;
      if (n !== 256) begin errs++; $display("FAIL en4_spacing: got %0d required %0d", n, 256); end
      vecs++;
      if (data !== 32'h8000_8000) begin errs++; $display("FAIL en4_word: got %h required %h", data, 32'h8000_8000); end
   endtask

   task automatic test_dr_change;
      int n;
      en_div = 1;
      @(posedge mclkin);
      #1 dec_log2 = 4'd8;
      wait_valid(1100, n);
      vecs++;
      if (n !== 1028) begin errs++; $display("FAIL dr8_after_change: got %0d required %0d", n, 1028); end
      repeat (100) @(posedge mclkin);
      #1 dec_log2 = 4'd10;
      @(posedge mclkin);
      @(posedge mclkin);
      @(negedge mclkin);
      vecs++;
      if ({data_valid, settled, data} !== {2'b00, 32'h0})
         begin errs++; $display("FAIL dr_change_clear: got %b/%b/%h required 0/0/%h", data_valid, settled, data, 32'h0); end
      wait_valid(3070, n);
      vecs++;
      if (n !== -1) begin errs++; $display("FAIL dr10_suppressed: got valid at %0d required none", n); end
      wait_valid(1100, n);
      vecs++;
      if (n !== 1028) begin errs++; $display("FAIL dr10_first_latency: got %0d required %0d", n, 1028); end
      vecs++;
      if (data !== 32'h8000_8000) begin errs++; $display("FAIL dr10_word: got %h required %h", data, 32'h8000_8000); end
      @(posedge mclkin);
      #1 dec_log2 = 4'd15;
      wait_valid(1100, n);
      vecs++;
      if (n !== 1028) begin errs++; $display("FAIL illegal_as_dr8: got %0d required %0d", n, 1028); end
      vecs++;
      if (data !== 32'h8000_8000) begin errs++; $display("FAIL illegal_word: got %h required %h", data, 32'h8000_8000); end
      wait_valid(300, n);
      vecs++;
      if (n !== 256) begin errs++; $display("FAIL illegal_spacing: got %0d required %0d", n, 256); end
   endtask

   task automatic test_reset_mid;
      int n;
      repeat (100) @(posedge mclkin);
      #1 rst = 1'b0;
      #1;
      vecs++;
      if ({data_valid, settled, data} !== {2'b00, 32'h0})
         begin errs++; $display("FAIL async_reset: got %b/%b/%h required 0/0/%h", data_valid, settled, data, 32'h0); end
      @(posedge mclkin);
      #1 rst = 1'b1;
      wait_valid(1100, n);
      vecs++;
      if (n !== 1026) begin errs++; $display("FAIL resettle_latency: got %0d required %0d", n, 1026); end
      vecs++;
      if (data !== 32'h8000_8000) begin errs++; $display("FAIL resettle_word: got %h required %h", data, 32'h8000_8000); end
   endtask

   initial begin
      test_reset;
      test_settle_ones;
      test_back_to_back;
      test_alt8;
      test_dr5;
      test_en_every4;
      test_dr_change;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
